// File: rtl/hazard_pkg.sv
// Shared op-class encodings and per-stage hazard tuple types, used by this
// pipe and by the hazard detection unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        OP_NONE   = 2'b00,
        OP_ALU    = 2'b01,
        OP_LOAD   = 2'b10,
        OP_BRANCH = 2'b11
    } optype_e;

    typedef struct packed {
        logic       valid;
        optype_e    optype;
        logic [4:0] rd;
        logic [4:0] rs2;
    } stage_info_t;

    // WB never forwards store data, so its slot has no rs2.
    typedef struct packed {
        logic       valid;
        optype_e    optype;
        logic [4:0] rd;
    } wb_info_t;

    localparam stage_info_t BUBBLE    = '{valid: 1'b0, optype: OP_NONE, rd: 5'd0, rs2: 5'd0};
    localparam wb_info_t    BUBBLE_WB = '{valid: 1'b0, optype: OP_NONE, rd: 5'd0};

    // An x0 write can never be a hazard, and only ALU/load ops write rd, so
    // downstream rd != 0 always implies optype is ALU or LOAD.
    function automatic stage_info_t normalize(input logic [1:0] optype,
                                              input logic [4:0] rd,
                                              input logic [4:0] rs2);
        stage_info_t info;
        logic        writes;
        writes      = (optype == OP_ALU) || (optype == OP_LOAD);
        info.valid  = 1'b1;
        info.optype = (writes && rd == 5'd0) ? OP_NONE : optype_e'(optype);
        info.rd     = writes ? rd : 5'd0;
        info.rs2    = rs2;
        return info;
    endfunction

endpackage

// File: rtl/hazard_info_pipe_if.sv
// ID-stage decode, pipeline-register controls and per-stage hazard metadata.
// The master side drives decode/controls; the slave side is the pipe itself.
interface hazard_info_pipe_if #(parameter int CNT_W = 16);

    logic [1:0]       hazard_optype_ID;
    logic [4:0]       rd_ID;
    logic [4:0]       rs2_ID;
    logic             reg_DE_EN;
    logic             reg_DE_flush;
    logic             reg_EM_EN;
    logic             reg_EM_flush;
    logic             reg_MW_EN;
    logic             reg_FD_stall;
    logic             cnt_clr;

    logic [1:0]       hazard_optype_ctrl_before1;
    logic [1:0]       hazard_optype_ctrl_before2;
    logic [1:0]       hazard_optype_ctrl_before3;
    logic [4:0]       rd_EXE;
    logic [4:0]       rd_MEM;
    logic [4:0]       rd_WB;
    logic [4:0]       rs2_EXE;
    logic             valid_EXE;
    logic             valid_MEM;
    logic             valid_WB;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output hazard_optype_ID, rd_ID, rs2_ID,
               reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN,
               reg_FD_stall, cnt_clr,
        input  hazard_optype_ctrl_before1, hazard_optype_ctrl_before2,
               hazard_optype_ctrl_before3, rd_EXE, rd_MEM, rd_WB, rs2_EXE,
               valid_EXE, valid_MEM, valid_WB, bubble_cnt, stall_cnt
    );

    modport slave (
        input  hazard_optype_ID, rd_ID, rs2_ID,
               reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN,
               reg_FD_stall, cnt_clr,
        output hazard_optype_ctrl_before1, hazard_optype_ctrl_before2,
               hazard_optype_ctrl_before3, rd_EXE, rd_MEM, rd_WB, rs2_EXE,
               valid_EXE, valid_MEM, valid_WB, bubble_cnt, stall_cnt
    );

endinterface

// File: rtl/hazard_info_pipe_sat_counter.sv
// Saturating event counter: clear beats increment, holds at all-ones.
module sat_counter #(parameter int W = 16) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/hazard_info_pipe.sv
// Tracks {valid, optype, rd, rs2} through EXE/MEM/WB in lockstep with the
// datapath registers, and counts bubble and stall cycles.
module hazard_info_pipe
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_info_pipe_if.slave bus
);

    stage_info_t      id_info;
    stage_info_t      exe_q;
    stage_info_t      mem_q;
    wb_info_t         wb_q;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] stall_cnt;

    assign id_info = normalize(bus.hazard_optype_ID, bus.rd_ID, bus.rs2_ID);

    // NOTE: reset is synchronous, so rst is only tested inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_q <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE_WB;
        end else begin
            // Flush dominates enable: a bubble goes in even while the stage is stalled.
            if (bus.reg_DE_flush) begin
                exe_q <= BUBBLE;
            end else if (bus.reg_DE_EN) begin
                exe_q <= id_info;
            end

            if (bus.reg_EM_flush) begin
                mem_q <= BUBBLE;
            end else if (bus.reg_EM_EN) begin
                mem_q <= exe_q;
            end

            if (bus.reg_MW_EN) begin
                wb_q <= '{valid: mem_q.valid, optype: mem_q.optype, rd: mem_q.rd};
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.cnt_clr),
        .inc (bus.reg_DE_flush || bus.reg_EM_flush),
        .cnt (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.cnt_clr),
        .inc (bus.reg_FD_stall),
        .cnt (stall_cnt)
    );

    assign bus.hazard_optype_ctrl_before1 = exe_q.optype;
    assign bus.hazard_optype_ctrl_before2 = mem_q.optype;
    assign bus.hazard_optype_ctrl_before3 = wb_q.optype;
    assign bus.rd_EXE                     = exe_q.rd;
    assign bus.rd_MEM                     = mem_q.rd;
    assign bus.rd_WB                      = wb_q.rd;
    assign bus.rs2_EXE                    = exe_q.rs2;
    assign bus.valid_EXE                  = exe_q.valid;
    assign bus.valid_MEM                  = mem_q.valid;
    assign bus.valid_WB                   = wb_q.valid;
    assign bus.bubble_cnt                 = bubble_cnt;
    assign bus.stall_cnt                  = stall_cnt;

endmodule

// File: tb/tb_hazard_info_pipe.sv
// Directed bench for hazard_info_pipe with 4-bit counters: stage advance,
// normalization, flush/hold, counter saturation and mid-stream reset.
module tb_hazard_info_pipe;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    hazard_info_pipe_if #(.CNT_W(CNT_W)) bus ();

    hazard_info_pipe #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs2);
        bus.hazard_optype_ID = op;
        bus.rd_ID            = rd;
        bus.rs2_ID           = rs2;
    endtask

    task automatic set_ctrl(input logic de_en, input logic de_fl, input logic em_en,
                            input logic em_fl, input logic mw_en, input logic stall,
                            input logic clr);
        bus.reg_DE_EN    = de_en;
        bus.reg_DE_flush = de_fl;
        bus.reg_EM_EN    = em_en;
        bus.reg_EM_flush = em_fl;
        bus.reg_MW_EN    = mw_en;
        bus.reg_FD_stall = stall;
        bus.cnt_clr      = clr;
    endtask

    task automatic check_exe(input string tag, input logic v, input logic [1:0] op,
                             input logic [4:0] rd, input logic [4:0] rs2);
        check(tag, {19'd0, bus.valid_EXE, bus.hazard_optype_ctrl_before1, bus.rd_EXE, bus.rs2_EXE},
                   {19'd0, v, op, rd, rs2});
    endtask

    task automatic check_mem(input string tag, input logic v, input logic [1:0] op, input logic [4:0] rd);
        check(tag, {24'd0, bus.valid_MEM, bus.hazard_optype_ctrl_before2, bus.rd_MEM},
                   {24'd0, v, op, rd});
    endtask

    task automatic check_wb(input string tag, input logic v, input logic [1:0] op, input logic [4:0] rd);
        check(tag, {24'd0, bus.valid_WB, bus.hazard_optype_ctrl_before3, bus.rd_WB},
                   {24'd0, v, op, rd});
    endtask

    task automatic check_cnts(input string tag, input logic [CNT_W-1:0] bub, input logic [CNT_W-1:0] stl);
        check({tag, "_bubble"}, 32'(bus.bubble_cnt), 32'(bub));
        check({tag, "_stall"},  32'(bus.stall_cnt),  32'(stl));
    endtask

    // Any nonzero rd downstream must belong to an ALU or load op.
    function automatic logic rd_invariant_ok(input logic [1:0] op, input logic [4:0] rd);
        return (rd == 5'd0) || (op == 2'b01) || (op == 2'b10);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("inv_exe", 32'(rd_invariant_ok(bus.hazard_optype_ctrl_before1, bus.rd_EXE)), 32'd1);
            check("inv_mem", 32'(rd_invariant_ok(bus.hazard_optype_ctrl_before2, bus.rd_MEM)), 32'd1);
            check("inv_wb",  32'(rd_invariant_ok(bus.hazard_optype_ctrl_before3, bus.rd_WB)),  32'd1);
        end
    end

    initial begin
        // Reset wins over enables, flushes and a live ID tuple.
        rst = 1'b1;
        set_id(2'b10, 5'd21, 5'd22);
        set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        check_exe("reset_exe", 1'b0, 2'b00, 5'd0, 5'd0);
        check_mem("reset_mem", 1'b0, 2'b00, 5'd0);
        check_wb("reset_wb", 1'b0, 2'b00, 5'd0);
        check_cnts("reset", 4'd0, 4'd0);

        // Load advances one stage per edge.
        rst = 1'b0;
        set_id(2'b10, 5'd5, 5'd7);
        set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check_exe("adv1_exe", 1'b1, 2'b10, 5'd5, 5'd7);
        check_mem("adv1_mem", 1'b0, 2'b00, 5'd0);
        step();
        check_mem("adv2_mem", 1'b1, 2'b10, 5'd5);
        check_wb("adv2_wb", 1'b0, 2'b00, 5'd0);
        step();
        check_wb("adv3_wb", 1'b1, 2'b10, 5'd5);

        // Normalization: ALU to x0 becomes none; branch never carries rd.
        set_id(2'b01, 5'd0, 5'd3);
        step();
        check_exe("x0_alu", 1'b1, 2'b00, 5'd0, 5'd3);
        set_id(2'b11, 5'd9, 5'd4);
        step();
        check_exe("branch_rd", 1'b1, 2'b11, 5'd0, 5'd4);
        check_mem("x0_alu_mem", 1'b1, 2'b00, 5'd0);

        // Load-use: flush DE with its enable low, stall IF/ID for one cycle.
        set_id(2'b10, 5'd6, 5'd2);
        step();
        check_exe("lu_load", 1'b1, 2'b10, 5'd6, 5'd2);
        check_cnts("lu_pre", 4'd0, 4'd0);
        set_id(2'b01, 5'd8, 5'd1);
        set_ctrl(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        check_exe("lu_bubble", 1'b0, 2'b00, 5'd0, 5'd0);
        check_mem("lu_mem", 1'b1, 2'b10, 5'd6);
        check_cnts("lu", 4'd1, 4'd1);

        // MEM hold for two cycles while EXE keeps loading.
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check_exe("hold1_exe", 1'b1, 2'b01, 5'd8, 5'd1);
        check_mem("hold1_mem", 1'b1, 2'b10, 5'd6);
        set_id(2'b10, 5'd12, 5'd13);
        step();
        check_exe("hold2_exe", 1'b1, 2'b10, 5'd12, 5'd13);
        check_mem("hold2_mem", 1'b1, 2'b10, 5'd6);
        check_wb("hold2_wb", 1'b1, 2'b10, 5'd6);

        // EM flush with EM enable low still bubbles MEM.
        set_id(2'b01, 5'd14, 5'd0);
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check_mem("emfl_mem", 1'b0, 2'b00, 5'd0);
        check_exe("emfl_exe", 1'b1, 2'b01, 5'd14, 5'd0);
        check_wb("emfl_wb", 1'b1, 2'b10, 5'd6);
        check_cnts("emfl", 4'd2, 4'd1);

        // Both flushes together: one bubble count, WB still takes old MEM.
        set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check_mem("pre_dual_mem", 1'b1, 2'b01, 5'd14);
        set_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check_exe("dual_exe", 1'b0, 2'b00, 5'd0, 5'd0);
        check_mem("dual_mem", 1'b0, 2'b00, 5'd0);
        check_wb("dual_wb", 1'b1, 2'b01, 5'd14);
        check_cnts("dual", 4'd3, 4'd1);

        // Clear, then saturate stall_cnt at 15 over 20 stall cycles.
        set_id(2'b01, 5'd3, 5'd2);
        set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        check_cnts("clr", 4'd0, 4'd0);
        set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step();
        check("sat_at15", 32'(bus.stall_cnt), 32'd15);
        for (int i = 0; i < 5; i++) step();
        check("sat_hold", 32'(bus.stall_cnt), 32'd15);
        check("sat_bubble", 32'(bus.bubble_cnt), 32'd0);
        set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        check("clr_prio", 32'(bus.stall_cnt), 32'd0);
        set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        check("post_clr", 32'(bus.stall_cnt), 32'd1);
        check_wb("full_wb", 1'b1, 2'b01, 5'd3);

        // Mid-stream reset discards every in-flight slot.
        rst = 1'b1;
        step();
        check_exe("mrst_exe", 1'b0, 2'b00, 5'd0, 5'd0);
        check_mem("mrst_mem", 1'b0, 2'b00, 5'd0);
        check_wb("mrst_wb", 1'b0, 2'b00, 5'd0);
        check_cnts("mrst", 4'd0, 4'd0);
        rst = 1'b0;
        set_id(2'b10, 5'd17, 5'd18);
        step();
        check_exe("post_rst_exe", 1'b1, 2'b10, 5'd17, 5'd18);
        check_mem("post_rst_mem", 1'b0, 2'b00, 5'd0);
        check("post_rst_stall", 32'(bus.stall_cnt), 32'd1);

        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_info_pipe.md
# hazard_info_pipe

Stage-tracking pipeline that produces the per-stage hazard metadata consumed by the hazard detection unit (`optype`, `rd`, `rs2`, valid for EXE/MEM/WB). It also obeys the enable/flush controls that unit emits, so it closes the loop from ID-stage decode to hazard detection. It sits beside the ID/EXE, EXE/MEM and MEM/WB datapath registers and advances in lockstep with them. Saturating event counters record bubble and stall cycles for performance debug.

## Interface
- `CNT_W`, default 16: width of each event counter.
- `clk`  in  1: pipeline clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `hazard_optype_ID`  in  2: ID-stage op class. 00 none, 01 ALU, 10 load, 11 branch.
- `rd_ID`, `rs2_ID`  in  5 each: ID-stage destination and rs2 register numbers.
- `reg_DE_EN`, `reg_DE_flush`  in  1 each: ID/EXE register enable and bubble insert.
- `reg_EM_EN`, `reg_EM_flush`  in  1 each: EXE/MEM register enable and bubble insert.
- `reg_MW_EN`  in  1: MEM/WB register enable.
- `reg_FD_stall`  in  1: IF/ID stall indication, used for counting only.
- `cnt_clr`  in  1: synchronous clear of both counters.
- `hazard_optype_ctrl_before1`, `hazard_optype_ctrl_before2`, `hazard_optype_ctrl_before3`  out  2 each: op class in EXE, MEM and WB.
- `rd_EXE`, `rd_MEM`, `rd_WB`  out  5 each: destination register per stage.
- `rs2_EXE`  out  5: rs2 of the instruction in EXE, for store-data forwarding.
- `valid_EXE`, `valid_MEM`, `valid_WB`  out  1 each: slot holds a real instruction.
- `bubble_cnt`  out  CNT_W: number of cycles with `reg_DE_flush` or `reg_EM_flush` asserted.
- `stall_cnt`  out  CNT_W: number of cycles with `reg_FD_stall` asserted.

## Operation
- Each stage slot holds the tuple {valid, optype, rd, rs2}. The WB slot drops rs2.
- **ID→EXE slot**, evaluated in priority order:
  - `reg_DE_flush`: load a bubble, {0, 00, 0, 0}.
  - else `reg_DE_EN`: load the normalized ID tuple with valid=1.
  - else: hold.
- **EXE→MEM slot**:
  - `reg_EM_flush`: load a bubble.
  - else `reg_EM_EN`: copy the EXE slot.
  - else: hold.
- **MEM→WB slot**:
  - `reg_MW_EN`: copy the MEM slot.
  - else: hold.
  - WB has no flush.
- **Normalization at ID capture**:
  - optype 01 or 10 with `rd_ID`==0 is stored as 00 with rd=0, since an x0 write is never a hazard.
  - optype 00 or 11 always stores rd=0.
  - rs2 is stored unchanged.
- Normalization means downstream rd≠0 implies optype ∈ {01, 10}. The bench checks this invariant every cycle.
- A flush on a stage whose enable is low still inserts a bubble, because flush dominates.
- A simultaneous flush on DE and EM bubbles both slots. WB still receives the old MEM content if `reg_MW_EN`=1.
- **Counters**:
  - Increment by 1 per qualifying cycle and saturate at all-ones, with no wrap.
  - `bubble_cnt` adds at most 1 per cycle even when both flushes are asserted.
  - `cnt_clr` zeroes both counters and takes priority over an increment in the same cycle.

## Timing
- All outputs are registered, so each is a direct slot or counter flop.
- ID inputs sampled at edge N appear on the `*_EXE` outputs after edge N. They reach MEM after edge N+1 and WB after edge N+2 when all enables are high.
- Control inputs take effect on the same edge they are sampled, with no extra latency.
- **Reset**:
  - At the edge with `rst`=1, every slot becomes a bubble: all optype 00, rd 0, rs2 0, valid 0.
  - Both counters become 0.
  - `rst` overrides every enable, flush and `cnt_clr`.
  - Reset mid-stream discards in-flight tuples. The first post-reset edge with `reg_DE_EN`=1 loads EXE normally.
- There is no combinational path from any input to any output.

## Structure
- Shared package `hazard_pkg`:
  - optype encodings `OP_NONE`=00, `OP_ALU`=01, `OP_LOAD`=10, `OP_BRANCH`=11.
  - stage tuple typedef `stage_info_t` {valid, optype[1:0], rd[4:0], rs2[4:0]}.
  - `BUBBLE` constant.
- The hazard detection unit imports the same package.
- One sub-module, `sat_counter` (param `W`; inputs clr, inc; output cnt), instantiated twice.
- Slot registers are inline.

## Test plan
- **Load advance**: reset, then drive ID {10, rd=5, rs2=7} with all EN=1 for 3 cycles. EXE shows {1,10,5,7} after edge 1, MEM shows {1,10,5} after edge 2, WB shows {1,10,5} after edge 3.
- **x0 destination**: drive ID {01, rd=0}, then {11, rd=9}. EXE shows optype 00 with rd 0, then optype 11 with rd 0.
- **Load-use bubble**: with a load in EXE, assert `reg_DE_flush` and `reg_FD_stall` for 1 cycle. Next cycle EXE is a bubble, MEM holds the load, and both counters equal 1.
- **Hold**: `reg_EM_EN`=0 with `reg_EM_flush`=0 for 2 cycles. MEM holds unchanged while EXE keeps loading. Then `reg_EM_flush`=1 with `reg_EM_EN`=0 makes MEM a bubble.
- **Counter saturation**: CNT_W=4, `reg_FD_stall`=1 for 20 cycles. `stall_cnt` stops at 15. `cnt_clr` together with `reg_FD_stall`=1 gives 0.
- **Reset mid-stream**: assert `rst` for 1 cycle with all slots valid and `reg_DE_EN`=1. All outputs read 0 on the next cycle.
